branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
- Controller for the ID-stage branch resolution datapath in the 5-stage MIPS pipeline.
- Branches and jumps resolve in ID from register-file operands, so this block:
  - selects forwarding sources for the rs/rt operands;
  - stalls IF/ID when an operand is not yet producible;
  - sequences the PC redirect, holding the target across IF (icache) stalls until the delay slot is fetched;
  - keeps branch performance counters.

Parameters:
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_instr  in  32  instruction in ID
- id_is_branch  in  1  taken/jump indication from branch datapath (ID)
- id_branch_pc  in  32  target from branch datapath (ID)
- ex_valid, ex_reg_write  in  1 each  EX stage instruction valid / writes GPR
- ex_dst  in  5  EX destination register
- mem_valid, mem_reg_write, mem_is_load  in  1 each  MEM stage status
- mem_dst  in  5  MEM destination register
- wb_valid, wb_reg_write  in  1 each  WB stage status
- wb_dst  in  5  WB destination register
- if_ready  in  1  IF can accept a new PC this cycle (no icache miss)
- ext_stall  in  1  global pipeline freeze (dcache miss etc.)
- fwd_rs_sel, fwd_rt_sel  out  2 each  ID operand source: 0 regfile, 1 MEM ALU result, 2 WB result
- stall_if, stall_id  out  1 each  hold PC / IF-ID register
- bubble_ex  out  1  insert NOP into ID/EX
- pc_redirect  out  1  PC mux selects pc_target
- pc_target  out  32  redirect address
- taken_cnt, stall_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - FSM is RUN, tgt_q=0, ds_flag=0, counters=0.
  - All outputs are forced to 0.
- Decode uses id_instr:
  - is_b = ~[31]&~[29]&[28]&~[27] (beq/bne).
  - is_j = ~[31]&~[29]&~[28]&[27].
  - is_jr = [31:26]==0 & [5:1]==5'b00100.
  - use_rs = is_b|is_jr; use_rt = is_b.
  - A source equal to register 0 never creates a hazard and always selects 0.
- Per-source hazard/forward resolution (combinational; priority EX > MEM > WB):
  - ex_valid&ex_reg_write&ex_dst==src -> hazard.
  - mem_valid&mem_reg_write&mem_dst==src&mem_is_load -> hazard.
  - mem match, not a load -> sel 1.
  - wb_valid&wb_reg_write&wb_dst==src -> sel 2.
  - Otherwise sel 0.
- hz = id_valid & (is_b|is_j|is_jr) & (hazard on a used source) & ~ds_flag.
  - hz -> stall_if=1, stall_id=1, bubble_ex=1.
  - No redirect while hz=1.
- take = id_valid & id_is_branch & ~hz & ~ds_flag & state==RUN.
- Consumption of a redirect = pc_redirect & if_ready & ~ext_stall.
- FSM:
  - RUN:
    - If take: pc_redirect=1, pc_target=id_branch_pc (same cycle, combinational).
    - If take, ~ext_stall, ~if_ready: latch tgt_q<=id_branch_pc and go to HOLD.
    - If take and consumed: set ds_flag and stay in RUN.
  - HOLD:
    - pc_redirect=1, pc_target=tgt_q.
    - id_is_branch is ignored.
    - On consumption: set ds_flag and go to RUN.
- ds_flag marks the next valid ID instruction as the delay slot.
  - It clears at the first cycle with id_valid & ~stall_id & ~ext_stall.
  - Branches in delay slots are not supported; they are suppressed and generate no redirect.
- ext_stall=1 freezes everything:
  - FSM, tgt_q, ds_flag and counters hold.
  - In RUN no latch occurs; pc_redirect may still be 1 but is not consumed.
  - stall_if/stall_id/bubble_ex still follow hz.
- Counters:
  - taken_cnt += 1 per consumed redirect.
  - stall_cnt += 1 per cycle with hz & ~ext_stall.
  - Both saturate at 2^CNT_W-1.
- Reset asserted mid-HOLD discards the pending target; after reset release there is no redirect.

Test Plan:
- beq $1,$2 with ex_dst=1, ex_reg_write=1, if_ready=1 -> cycle 1: stall_if=stall_id=bubble_ex=1, stall_cnt=1. Next cycle (producer now in MEM, non-load), id_is_branch=1, id_branch_pc=0x00400020 -> fwd_rs_sel=1, pc_redirect=1, pc_target=0x00400020, taken_cnt=1.
- lw to $3 in MEM, jr $3 in ID -> hazard for 1 cycle. Following cycle (lw in WB) -> fwd_rs_sel=2 and redirect to id_branch_pc.
- Taken j with id_branch_pc=0x00401000, if_ready=0 for 3 cycles -> enter HOLD. pc_redirect=1 and pc_target=0x00401000 on all 4 cycles; consumed when if_ready rises; taken_cnt increments exactly once.
- Branch with rs=rt=$0 while EX writes $0 -> no stall, fwd sels 0.
- Redirect consumed, then delay slot in ID is a beq with id_is_branch=1 -> pc_redirect=0. The next branch after the delay slot redirects normally.
- rst_n pulsed low while in HOLD -> all outputs 0 immediately. After release: pc_redirect=0, counters 0, state RUN.

Source files
------------

// File: rtl/branch_hazard_if.sv
// Bundle between the ID-stage branch controller and the surrounding pipeline:
// stage status and branch datapath results in, forwarding/stall/redirect
// controls and performance counters out.
interface branch_hazard_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [31:0]      id_instr;
    logic             id_is_branch;
    logic [31:0]      id_branch_pc;
    logic             ex_valid;
    logic             ex_reg_write;
    logic [4:0]       ex_dst;
    logic             mem_valid;
    logic             mem_reg_write;
    logic             mem_is_load;
    logic [4:0]       mem_dst;
    logic             wb_valid;
    logic             wb_reg_write;
    logic [4:0]       wb_dst;
    logic             if_ready;
    logic             ext_stall;
    logic [1:0]       fwd_rs_sel;
    logic [1:0]       fwd_rt_sel;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: drives stage status, consumes the controls.
    modport master (
        output id_valid, id_instr, id_is_branch, id_branch_pc,
        output ex_valid, ex_reg_write, ex_dst,
        output mem_valid, mem_reg_write, mem_is_load, mem_dst,
        output wb_valid, wb_reg_write, wb_dst,
        output if_ready, ext_stall,
        input  fwd_rs_sel, fwd_rt_sel, stall_if, stall_id, bubble_ex,
        input  pc_redirect, pc_target, taken_cnt, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_instr, id_is_branch, id_branch_pc,
        input  ex_valid, ex_reg_write, ex_dst,
        input  mem_valid, mem_reg_write, mem_is_load, mem_dst,
        input  wb_valid, wb_reg_write, wb_dst,
        input  if_ready, ext_stall,
        output fwd_rs_sel, fwd_rt_sel, stall_if, stall_id, bubble_ex,
        output pc_redirect, pc_target, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution controller for the 5-stage MIPS pipeline.
// Selects rs/rt forwarding sources, stalls IF/ID when an operand cannot be
// produced yet, sequences the PC redirect (holding the target across icache
// stalls until the delay slot is fetched) and counts taken branches and stalls.
module branch_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    branch_hazard_if.slave  bus
);
    typedef enum logic {RUN, HOLD} state_t;

    state_t           r_state;
    logic [31:0]      r_tgt;
    logic             r_ds;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_is_b;
    logic             w_is_j;
    logic             w_is_jr;
    logic             w_use_rs;
    logic             w_use_rt;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [2:0]       w_rs_res;
    logic [2:0]       w_rt_res;
    logic             w_hz;
    logic             w_take;
    logic             w_redirect;
    logic [31:0]      w_target;
    logic             w_consume;
    logic             w_unused;

    // Resolve one source operand; result is {hazard, sel[1:0]}.
    // The youngest producer wins; EX results and MEM loads are not yet
    // available in ID, so they stall instead of forwarding.
    function automatic logic [2:0] resolve(
        input logic [4:0] src,
        input logic       ex_w,
        input logic [4:0] ex_d,
        input logic       mem_w,
        input logic       mem_ld,
        input logic [4:0] mem_d,
        input logic       wb_w,
        input logic [4:0] wb_d
    );
        if (src == 5'd0)                 return 3'b000;
        if (ex_w && (ex_d == src))       return 3'b100;
        if (mem_w && (mem_d == src))     return mem_ld ? 3'b100 : 3'b001;
        if (wb_w && (wb_d == src))       return 3'b010;
        return 3'b000;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign w_rs     = bus.id_instr[25:21];
    assign w_rt     = bus.id_instr[20:16];
    assign w_is_b   = ~bus.id_instr[31] & ~bus.id_instr[29] &  bus.id_instr[28] & ~bus.id_instr[27];
    assign w_is_j   = ~bus.id_instr[31] & ~bus.id_instr[29] & ~bus.id_instr[28] &  bus.id_instr[27];
    assign w_is_jr  = (bus.id_instr[31:26] == 6'd0) & (bus.id_instr[5:1] == 5'b00100);
    assign w_use_rs = w_is_b | w_is_jr;
    assign w_use_rt = w_is_b;
    assign w_unused = ^{bus.id_instr[15:6], bus.id_instr[0]};

    assign w_rs_res = resolve(w_rs, bus.ex_valid & bus.ex_reg_write, bus.ex_dst,
                              bus.mem_valid & bus.mem_reg_write, bus.mem_is_load, bus.mem_dst,
                              bus.wb_valid & bus.wb_reg_write, bus.wb_dst);
    assign w_rt_res = resolve(w_rt, bus.ex_valid & bus.ex_reg_write, bus.ex_dst,
                              bus.mem_valid & bus.mem_reg_write, bus.mem_is_load, bus.mem_dst,
                              bus.wb_valid & bus.wb_reg_write, bus.wb_dst);

    // Hazard, take decision and redirect selection.
    always_comb begin
        w_hz       = bus.id_valid & (w_is_b | w_is_j | w_is_jr)
                   & ((w_use_rs & w_rs_res[2]) | (w_use_rt & w_rt_res[2])) & ~r_ds;
        w_take     = bus.id_valid & bus.id_is_branch & ~w_hz & ~r_ds & (r_state == RUN);
        w_redirect = ~w_hz & ((r_state == HOLD) | w_take);
        w_target   = 32'd0;
        if (w_redirect) w_target = (r_state == HOLD) ? r_tgt : bus.id_branch_pc;
        w_consume  = w_redirect & bus.if_ready & ~bus.ext_stall;
    end

    // Outputs are forced to zero while reset is asserted.
    assign bus.fwd_rs_sel  = rst_n ? w_rs_res[1:0] : 2'd0;
    assign bus.fwd_rt_sel  = rst_n ? w_rt_res[1:0] : 2'd0;
    assign bus.stall_if    = rst_n & w_hz;
    assign bus.stall_id    = rst_n & w_hz;
    assign bus.bubble_ex   = rst_n & w_hz;
    assign bus.pc_redirect = rst_n & w_redirect;
    assign bus.pc_target   = rst_n ? w_target : 32'd0;
    assign bus.taken_cnt   = r_taken_cnt;
    assign bus.stall_cnt   = r_stall_cnt;

    // Redirect sequencer: hold the target while IF cannot accept it, and mark
    // the following ID instruction as the delay slot once it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_tgt   <= 32'd0;
            r_ds    <= 1'b0;
        end else if (!bus.ext_stall) begin
            case (r_state)
                RUN: begin
                    if (w_take && !bus.if_ready) begin
                        r_state <= HOLD;
                        r_tgt   <= bus.id_branch_pc;
                    end
                end
                HOLD: begin
                    if (w_consume) r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
            if (w_consume)
                r_ds <= 1'b1;
            else if (r_ds && bus.id_valid && !w_hz)
                r_ds <= 1'b0;
        end
    end

    // Saturating performance counters, frozen by the global stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (!bus.ext_stall) begin
            r_taken_cnt <= sat_inc(r_taken_cnt, w_consume);
            r_stall_cnt <= sat_inc(r_stall_cnt, w_hz);
        end
    end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Randomized and directed bench for branch_hazard_ctrl against a behavioural
// model of the redirect/hazard rules. Narrow counters exercise saturation.
module tb_branch_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    branch_hazard_if #(.CNT_W(CNT_W)) bus();

    branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: a redirect waiting on the icache, the delay-slot mark, counters.
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_ds;
    int          m_taken;
    int          m_stall;

    // Expected outputs for the current cycle.
    logic [1:0]  e_rs_sel, e_rt_sel;
    logic        e_hz, e_redir;
    logic [31:0] e_tgt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] i_beq(input int rs, input int rt);
        logic [4:0] a = rs[4:0];
        logic [4:0] b = rt[4:0];
        return {6'd4, a, b, 16'h0010};
    endfunction

    function automatic logic [31:0] i_jr(input int rs);
        logic [4:0] a = rs[4:0];
        return {6'd0, a, 15'd0, 6'd8};
    endfunction

    localparam logic [31:0] I_J   = {6'd2, 26'h0100400};
    localparam logic [31:0] I_NOP = 32'd0;

    // Walk producers youngest-first; first writer of src decides.
    task automatic ref_src(input logic [4:0] src, output logic hz, output logic [1:0] sel);
        logic       wr  [3];
        logic [4:0] dst [3];
        wr[0] = bus.ex_valid  && bus.ex_reg_write;  dst[0] = bus.ex_dst;
        wr[1] = bus.mem_valid && bus.mem_reg_write; dst[1] = bus.mem_dst;
        wr[2] = bus.wb_valid  && bus.wb_reg_write;  dst[2] = bus.wb_dst;
        hz = 1'b0; sel = 2'd0;
        if (src != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (wr[k] && dst[k] == src) begin
                    if (k == 0 || (k == 1 && bus.mem_is_load)) hz = 1'b1;
                    else sel = (k == 1) ? 2'd1 : 2'd2;
                    break;
                end
            end
        end
    endtask

    task automatic model_eval();
        int         op, fn;
        logic       b, j, jr, hrs, hrt, take;
        op = int'(bus.id_instr[31:26]);
        fn = int'(bus.id_instr[5:0]);
        b  = (op == 4 || op == 5 || op == 20 || op == 21);
        j  = (op == 2 || op == 3 || op == 18 || op == 19);
        jr = (op == 0 && (fn == 8 || fn == 9));
        ref_src(bus.id_instr[25:21], hrs, e_rs_sel);
        ref_src(bus.id_instr[20:16], hrt, e_rt_sel);
        e_hz    = bus.id_valid && (b || j || jr) && (((b || jr) && hrs) || (b && hrt)) && !m_ds;
        take    = bus.id_valid && bus.id_is_branch && !e_hz && !m_ds && !m_pend;
        e_redir = !e_hz && (m_pend || take);
        e_tgt   = !e_redir ? 32'd0 : (m_pend ? m_tgt : bus.id_branch_pc);
        if (!bus.ext_stall) begin
            if (e_redir && bus.if_ready) begin
                m_pend  = 1'b0;
                m_ds    = 1'b1;
                m_taken = (m_taken < CMAX) ? m_taken + 1 : CMAX;
            end else begin
                if (take) begin
                    m_pend = 1'b1;
                    m_tgt  = bus.id_branch_pc;
                end
                if (m_ds && bus.id_valid && !e_hz) m_ds = 1'b0;
            end
            if (e_hz) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end
    endtask

    // Check at the falling edge (counters still show pre-edge values), then
    // let the rising edge apply; returns shortly after it.
    task automatic step();
        int t0, s0;
        @(negedge clk);
        t0 = m_taken; s0 = m_stall;
        model_eval();
        check_val("fwd_rs_sel",  32'(bus.fwd_rs_sel),  32'(e_rs_sel));
        check_val("fwd_rt_sel",  32'(bus.fwd_rt_sel),  32'(e_rt_sel));
        check_val("stall_if",    32'(bus.stall_if),    32'(e_hz));
        check_val("stall_id",    32'(bus.stall_id),    32'(e_hz));
        check_val("bubble_ex",   32'(bus.bubble_ex),   32'(e_hz));
        check_val("pc_redirect", 32'(bus.pc_redirect), 32'(e_redir));
        check_val("pc_target",   bus.pc_target,        e_tgt);
        check_val("taken_cnt",   32'(bus.taken_cnt),   32'(t0));
        check_val("stall_cnt",   32'(bus.stall_cnt),   32'(s0));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_valid = 1'b0; bus.id_instr = I_NOP; bus.id_is_branch = 1'b0; bus.id_branch_pc = 32'd0;
        bus.ex_valid = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dst = 5'd0;
        bus.mem_valid = 1'b0; bus.mem_reg_write = 1'b0; bus.mem_is_load = 1'b0; bus.mem_dst = 5'd0;
        bus.wb_valid = 1'b0; bus.wb_reg_write = 1'b0; bus.wb_dst = 5'd0;
        bus.if_ready = 1'b1; bus.ext_stall = 1'b0;
    endtask

    // Assert reset mid-cycle, verify outputs drop at once, release away from the edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst pc_redirect", 32'(bus.pc_redirect), 32'd0);
        check_val("rst pc_target",   bus.pc_target,        32'd0);
        check_val("rst stall_if",    32'(bus.stall_if),    32'd0);
        check_val("rst stall_id",    32'(bus.stall_id),    32'd0);
        check_val("rst bubble_ex",   32'(bus.bubble_ex),   32'd0);
        check_val("rst fwd_rs_sel",  32'(bus.fwd_rs_sel),  32'd0);
        check_val("rst fwd_rt_sel",  32'(bus.fwd_rt_sel),  32'd0);
        check_val("rst taken_cnt",   32'(bus.taken_cnt),   32'd0);
        check_val("rst stall_cnt",   32'(bus.stall_cnt),   32'd0);
        m_pend = 1'b0; m_tgt = 32'd0; m_ds = 1'b0; m_taken = 0; m_stall = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        bus.id_valid = 1'b1;
        bus.id_instr = I_J;
        bus.id_is_branch = 1'b1;
        bus.id_branch_pc = 32'h0000_0bad;
        bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd3;
        @(posedge clk);
        #1;
        pulse_reset();
        idle_inputs();

        // beq $1,$2 behind an EX writer of $1, then forwarded from MEM.
        bus.id_valid = 1'b1; bus.id_instr = i_beq(1, 2);
        bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd1;
        step();
        bus.ex_valid = 1'b0;
        bus.mem_valid = 1'b1; bus.mem_reg_write = 1'b1; bus.mem_dst = 5'd1;
        bus.id_is_branch = 1'b1; bus.id_branch_pc = 32'h0040_0020;
        step();
        // Delay slot holds a taken beq: suppressed.
        idle_inputs();
        bus.id_valid = 1'b1; bus.id_instr = i_beq(4, 5);
        bus.id_is_branch = 1'b1; bus.id_branch_pc = 32'h0040_0100;
        step();
        // Next branch after the delay slot redirects normally.
        bus.id_instr = i_beq(6, 7); bus.id_branch_pc = 32'h0040_0200;
        step();
        idle_inputs();
        step();

        // lw $3 in MEM with jr $3 in ID, then lw in WB.
        bus.id_valid = 1'b1; bus.id_instr = i_jr(3);
        bus.mem_valid = 1'b1; bus.mem_reg_write = 1'b1; bus.mem_is_load = 1'b1; bus.mem_dst = 5'd3;
        step();
        bus.mem_valid = 1'b0; bus.mem_is_load = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_reg_write = 1'b1; bus.wb_dst = 5'd3;
        bus.id_is_branch = 1'b1; bus.id_branch_pc = 32'h0040_0300;
        step();
        idle_inputs();
        step();

        // Branch on $0 while EX writes $0: no hazard.
        bus.id_valid = 1'b1; bus.id_instr = i_beq(0, 0);
        bus.ex_valid = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dst = 5'd0;
        step();
        idle_inputs();
        step();

        // Taken j with IF busy for 3 cycles, consumed on the 4th.
        bus.id_valid = 1'b1; bus.id_instr = I_J;
        bus.id_is_branch = 1'b1; bus.id_branch_pc = 32'h0040_1000;
        bus.if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.id_branch_pc = 32'h0040_1000 + 32'(k + 1) * 32'h40;
        end
        bus.if_ready = 1'b1;
        step();
        idle_inputs();
        step();

        // Enter HOLD and reset in the middle of it.
        bus.id_valid = 1'b1; bus.id_instr = I_J;
        bus.id_is_branch = 1'b1; bus.id_branch_pc = 32'h0040_2000;
        bus.if_ready = 1'b0;
        step();
        step();
        pulse_reset();
        idle_inputs();
        step();
        step();

        // Random traffic with small register numbers to provoke matches.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [4:0] rs, rt;
            sel = int'($urandom_range(0, 7));
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            case (sel)
                0, 1: bus.id_instr = {6'd4, rs, rt, 16'($urandom)};
                2:    bus.id_instr = {6'd5, rs, rt, 16'($urandom)};
                3:    bus.id_instr = {6'd2, 26'($urandom)};
                4:    bus.id_instr = {6'd0, rs, 10'($urandom), 5'd0, 6'(8 + $urandom_range(0, 1))};
                5:    bus.id_instr = {6'd8, rs, rt, 16'($urandom)};
                6:    bus.id_instr = {6'd20, rs, rt, 16'($urandom)};
                default: bus.id_instr = {6'd35, rs, rt, 16'($urandom)};
            endcase
            bus.id_valid      = ($urandom_range(0, 9) < 8);
            bus.id_is_branch  = ($urandom_range(0, 1) == 1);
            bus.id_branch_pc  = $urandom;
            bus.ex_valid      = ($urandom_range(0, 1) == 1);
            bus.ex_reg_write  = ($urandom_range(0, 1) == 1);
            bus.ex_dst        = 5'($urandom_range(0, 3));
            bus.mem_valid     = ($urandom_range(0, 1) == 1);
            bus.mem_reg_write = ($urandom_range(0, 1) == 1);
            bus.mem_is_load   = ($urandom_range(0, 2) == 0);
            bus.mem_dst       = 5'($urandom_range(0, 3));
            bus.wb_valid      = ($urandom_range(0, 1) == 1);
            bus.wb_reg_write  = ($urandom_range(0, 1) == 1);
            bus.wb_dst        = 5'($urandom_range(0, 3));
            bus.if_ready      = ($urandom_range(0, 9) < 7);
            bus.ext_stall     = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
